// File: rtl/ahb_slave_arbiter.sv
// ahb_slave_arbiter: per-slave round-robin arbiter for the AHB interconnect.
// It takes the per-master hreq bits from the address decoders and grants the
// slave to one master at a time. The grant is held until the burst ends.
// It also drives the address-phase and data-phase master indices for the
// slave-side muxes.
// Optional feature: define AHB_ARB_LOCK_EN to add the hlock_sel input. While
// hlock_sel is high, the current owner keeps the slave across bursts.
module ahb_slave_arbiter #(
  parameter int MASTER_NUM = 4,
  parameter int MIDX_W     = $clog2(MASTER_NUM)
) (
  input  logic                  hclk,
  input  logic                  hreset_n,
  input  logic [MASTER_NUM-1:0] hreq,
  input  logic [1:0]            htrans_sel,
  input  logic [2:0]            hburst_sel,
  input  logic                  hready_slv,
`ifdef AHB_ARB_LOCK_EN
  input  logic                  hlock_sel,
`endif
  output logic [MASTER_NUM-1:0] hgrant,
  output logic [MIDX_W-1:0]     hmaster_sel,
  output logic [MIDX_W-1:0]     hmaster_data,
  output logic                  hsel_slv
);

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;

  localparam logic [2:0] BURST_SINGLE = 3'b000;
  localparam logic [2:0] BURST_INCR   = 3'b001;
  localparam logic [2:0] BURST_WRAP4  = 3'b010;
  localparam logic [2:0] BURST_INCR4  = 3'b011;
  localparam logic [2:0] BURST_WRAP8  = 3'b100;
  localparam logic [2:0] BURST_INCR8  = 3'b101;
  localparam logic [2:0] BURST_WRAP16 = 3'b110;
  localparam logic [2:0] BURST_INCR16 = 3'b111;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_OWN  = 1'b1
  } arb_state_t;

  arb_state_t state_q, state_d;

  logic [MASTER_NUM-1:0] grant_d;
  logic [MIDX_W-1:0]     sel_d;
  logic [MIDX_W-1:0]     rr_q, rr_d;
  logic [4:0]            cnt_q, cnt_d;

  logic                  rr_found;
  logic [MIDX_W-1:0]     rr_winner;
  logic [MIDX_W-1:0]     rr_after;
  logic [MIDX_W:0]       cand;

  logic [4:0]            burst_len_m1;
  logic                  nonseq_acc;
  logic                  seq_acc;
  logic                  last_beat;
  logic                  owner_req;
  logic                  lock_hold;
  logic                  do_release;

`ifdef AHB_ARB_LOCK_EN
  assign lock_hold = hlock_sel;
`else
  assign lock_hold = 1'b0;
`endif

  assign owner_req  = |(hreq & hgrant);
  assign nonseq_acc = (state_q == ARB_OWN) && hready_slv && (htrans_sel == TRANS_NONSEQ);
  assign seq_acc    = (state_q == ARB_OWN) && hready_slv && (htrans_sel == TRANS_SEQ);

  // The last beat of a fixed-length burst is either a SINGLE NONSEQ or the
  // SEQ beat that arrives with one beat left on the counter.
  assign last_beat = (nonseq_acc && (hburst_sel == BURST_SINGLE)) ||
                     (seq_acc && (hburst_sel != BURST_INCR) &&
                      (hburst_sel != BURST_SINGLE) && (cnt_q == 5'd1));

  // A release is only acted on in accepted cycles, and never while the owner is locked.
  assign do_release = (state_q == ARB_OWN) && hready_slv && !lock_hold &&
                      ((htrans_sel == TRANS_IDLE) || !owner_req || last_beat);

  assign hsel_slv = (|hgrant) && htrans_sel[1];

  // Number of beats remaining after the first beat of a burst. INCR has no
  // fixed length, so it loads 0 and can never end on a count.
  always_comb begin
    burst_len_m1 = 5'd0;
    case (hburst_sel)
      BURST_SINGLE: burst_len_m1 = 5'd0;
      BURST_INCR:   burst_len_m1 = 5'd0;
      BURST_WRAP4:  burst_len_m1 = 5'd3;
      BURST_INCR4:  burst_len_m1 = 5'd3;
      BURST_WRAP8:  burst_len_m1 = 5'd7;
      BURST_INCR8:  burst_len_m1 = 5'd7;
      BURST_WRAP16: burst_len_m1 = 5'd15;
      BURST_INCR16: burst_len_m1 = 5'd15;
      default:      burst_len_m1 = 5'd0;
    endcase
  end

  // Round-robin search from the pointer. The previous owner sits last in this
  // order, so it only wins when no other master is requesting.
  always_comb begin
    rr_found  = 1'b0;
    rr_winner = '0;
    cand      = '0;
    for (int i = 0; i < MASTER_NUM; i++) begin
      cand = {1'b0, rr_q} + (MIDX_W+1)'(i);
      if (cand >= (MIDX_W+1)'(MASTER_NUM)) begin
        cand = cand - (MIDX_W+1)'(MASTER_NUM);
      end
      if (!rr_found && hreq[cand[MIDX_W-1:0]]) begin
        rr_found  = 1'b1;
        rr_winner = cand[MIDX_W-1:0];
      end
    end
    rr_after = (rr_winner == MIDX_W'(MASTER_NUM-1)) ? '0 : rr_winner + MIDX_W'(1);
  end

  // Next-state logic: this block updates the beat counter and makes the grant
  // and handover decisions.
  always_comb begin
    state_d = state_q;
    grant_d = hgrant;
    sel_d   = hmaster_sel;
    rr_d    = rr_q;
    cnt_d   = cnt_q;

    if (nonseq_acc) begin
      cnt_d = burst_len_m1;
    end else if (seq_acc && (cnt_q != 5'd0)) begin
      cnt_d = cnt_q - 5'd1;
    end

    case (state_q)
      ARB_IDLE: begin
        if (hready_slv && rr_found) begin
          state_d            = ARB_OWN;
          grant_d            = '0;
          grant_d[rr_winner] = 1'b1;
          sel_d              = rr_winner;
          rr_d               = rr_after;
        end
      end
      ARB_OWN: begin
        if (do_release) begin
          if (rr_found) begin
            grant_d            = '0;
            grant_d[rr_winner] = 1'b1;
            sel_d              = rr_winner;
            rr_d               = rr_after;
          end else begin
            state_d = ARB_IDLE;
            grant_d = '0;
          end
        end
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State registers. The data-phase index follows the address-phase index
  // on every accepted cycle.
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state_q      <= ARB_IDLE;
      hgrant       <= '0;
      hmaster_sel  <= '0;
      hmaster_data <= '0;
      rr_q         <= '0;
      cnt_q        <= '0;
    end else begin
      state_q     <= state_d;
      hgrant      <= grant_d;
      hmaster_sel <= sel_d;
      rr_q        <= rr_d;
      cnt_q       <= cnt_d;
      if (hready_slv) begin
        hmaster_data <= hmaster_sel;
      end
    end
  end

endmodule

// File: tb/tb_ahb_slave_arbiter.sv
// tb_ahb_slave_arbiter: testbench for ahb_slave_arbiter using directed vectors
// and a scoreboard. The stimulus queues the expected outputs for each cycle,
// and a monitor on the falling edge compares them against the DUT.
// Lock scenarios are built in when AHB_ARB_LOCK_EN is defined.
module tb_ahb_slave_arbiter;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] BUSY   = 2'b01;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;

  localparam logic [2:0] SINGLE = 3'b000;
  localparam logic [2:0] INCR   = 3'b001;
  localparam logic [2:0] INCR4  = 3'b011;
  localparam logic [2:0] INCR8  = 3'b101;

  localparam logic [3:0] M_ALL = 4'b1111;
  localparam logic [3:0] M_GSH = 4'b1011;
  localparam logic [3:0] M_GH  = 4'b1001;

  logic       hclk = 1'b0;
  logic       hreset_n;
  logic [3:0] hreq;
  logic [1:0] htrans_sel;
  logic [2:0] hburst_sel;
  logic       hready_slv;
  logic [3:0] hgrant;
  logic [1:0] hmaster_sel;
  logic [1:0] hmaster_data;
  logic       hsel_slv;
`ifdef AHB_ARB_LOCK_EN
  logic       hlock_sel;
  logic       lock_next;
`endif

  typedef struct {
    int         cyc;
    string      name;
    logic [3:0] grant;
    logic [1:0] sel;
    logic [1:0] data;
    logic       hsel;
    logic [3:0] mask;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   cyc_cnt    = 0;
  int   checks     = 0;
  int   failures   = 0;
  bit   stim_done  = 1'b0;

  ahb_slave_arbiter #(.MASTER_NUM(4)) dut (
    .hclk        (hclk),
    .hreset_n    (hreset_n),
    .hreq        (hreq),
    .htrans_sel  (htrans_sel),
    .hburst_sel  (hburst_sel),
    .hready_slv  (hready_slv),
`ifdef AHB_ARB_LOCK_EN
    .hlock_sel   (hlock_sel),
`endif
    .hgrant      (hgrant),
    .hmaster_sel (hmaster_sel),
    .hmaster_data(hmaster_data),
    .hsel_slv    (hsel_slv)
  );

  always #5 hclk = ~hclk;

  always @(posedge hclk) cyc_cnt <= cyc_cnt + 1;

  // Drive one cycle's inputs just after the rising edge and queue the
  // outputs expected during that cycle.
  task automatic applyStimulus(input string name, input logic rst_n, input logic [3:0] req,
                               input logic [1:0] trans, input logic [2:0] burst, input logic rdy,
                               input logic [3:0] eg, input logic [1:0] es, input logic [1:0] ed,
                               input logic eh, input logic [3:0] mask);
    exp_t e;
    @(posedge hclk);
    #1;
    hreset_n   = rst_n;
    hreq       = req;
    htrans_sel = trans;
    hburst_sel = burst;
    hready_slv = rdy;
`ifdef AHB_ARB_LOCK_EN
    hlock_sel  = lock_next;
`endif
    e.cyc   = cyc_cnt;
    e.name  = name;
    e.grant = eg;
    e.sel   = es;
    e.data  = ed;
    e.hsel  = eh;
    e.mask  = mask;
    exp_q.push_back(e);
  endtask

  task automatic checkField(input string name, input string field,
                            input logic [3:0] act, input logic [3:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("[TB] FAIL %s.%s at cycle %0d: got %0h, expected %0h", name, field, cyc_cnt, act, exp);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    if (e.mask[0]) checkField(e.name, "hgrant", hgrant, e.grant);
    if (e.mask[1]) checkField(e.name, "hmaster_sel", {2'b00, hmaster_sel}, {2'b00, e.sel});
    if (e.mask[2]) checkField(e.name, "hmaster_data", {2'b00, hmaster_data}, {2'b00, e.data});
    if (e.mask[3]) checkField(e.name, "hsel_slv", {3'b000, hsel_slv}, {3'b000, e.hsel});
  endtask

  // Monitor: compare the queued expectations mid-cycle, away from the clock edge.
  always @(negedge hclk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc_cnt) begin
      cur = exp_q.pop_front();
      if (cur.cyc != cyc_cnt) begin
        checks   = checks + 1;
        failures = failures + 1;
        $display("[TB] FAIL %s: stale entry for cycle %0d, now cycle %0d", cur.name, cur.cyc, cyc_cnt);
      end else begin
        checkOutput(cur);
      end
    end
    if (stim_done) begin
      if (exp_q.size() != 0) begin
        checks   = checks + 1;
        failures = failures + 1;
        $display("[TB] FAIL drain: got %0d unchecked entries, expected 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  // Watchdog in case the clock or the stimulus stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios with hand-computed outputs for every cycle.
  initial begin
    hreset_n   = 1'b0;
    hreq       = 4'b0000;
    htrans_sel = IDLE;
    hburst_sel = SINGLE;
    hready_slv = 1'b1;
`ifdef AHB_ARB_LOCK_EN
    hlock_sel  = 1'b0;
    lock_next  = 1'b0;
`endif
    repeat (3) @(posedge hclk);
    $display("[TB] start");

    applyStimulus("reset_hold", 1'b0, 4'b1111, IDLE, SINGLE, 1'b1, 4'b0000, 2'd0, 2'd0, 1'b0, M_ALL);

    // Round-robin: four requesters, each issues one SINGLE.
    applyStimulus("rr_start", 1'b1, 4'b1111, IDLE,   SINGLE, 1'b1, 4'b0000, 2'd0, 2'd0, 1'b0, M_ALL);
    applyStimulus("rr_g0",    1'b1, 4'b1111, NONSEQ, SINGLE, 1'b1, 4'b0001, 2'd0, 2'd0, 1'b1, M_ALL);
    applyStimulus("rr_g1",    1'b1, 4'b1111, NONSEQ, SINGLE, 1'b1, 4'b0010, 2'd1, 2'd0, 1'b1, M_ALL);
    applyStimulus("rr_g2",    1'b1, 4'b1111, NONSEQ, SINGLE, 1'b1, 4'b0100, 2'd2, 2'd1, 1'b1, M_ALL);
    applyStimulus("rr_g3",    1'b1, 4'b1111, NONSEQ, SINGLE, 1'b1, 4'b1000, 2'd3, 2'd2, 1'b1, M_ALL);
    applyStimulus("rr_g0b",   1'b1, 4'b0000, IDLE,   SINGLE, 1'b1, 4'b0001, 2'd0, 2'd3, 1'b0, M_ALL);
    applyStimulus("rr_idle",  1'b1, 4'b0000, IDLE,   SINGLE, 1'b1, 4'b0000, 2'd0, 2'd0, 1'b0, M_GH);

    // Sole requester: master 0 is re-granted and the grant never drops.
    applyStimulus("sole_req", 1'b1, 4'b0001, IDLE,   SINGLE, 1'b1, 4'b0000, 2'd0, 2'd0, 1'b0, M_GH);
    applyStimulus("sole_s1",  1'b1, 4'b0001, NONSEQ, SINGLE, 1'b1, 4'b0001, 2'd0, 2'd0, 1'b1, M_GSH);
    applyStimulus("sole_s2",  1'b1, 4'b0001, NONSEQ, SINGLE, 1'b1, 4'b0001, 2'd0, 2'd0, 1'b1, M_ALL);
    applyStimulus("sole_s3",  1'b1, 4'b0001, NONSEQ, SINGLE, 1'b1, 4'b0001, 2'd0, 2'd0, 1'b1, M_ALL);
    applyStimulus("sole_end", 1'b1, 4'b0000, IDLE,   SINGLE, 1'b1, 4'b0001, 2'd0, 2'd0, 1'b0, M_ALL);
    applyStimulus("sole_idl", 1'b1, 4'b0000, IDLE,   SINGLE, 1'b1, 4'b0000, 2'd0, 2'd0, 1'b0, M_GH);

    // INCR4 from master 1 with two wait states; master 3 waits its turn.
    applyStimulus("i4_req",   1'b1, 4'b0010, IDLE,   INCR4,  1'b1, 4'b0000, 2'd0, 2'd0, 1'b0, M_GH);
    applyStimulus("i4_b1",    1'b1, 4'b1010, NONSEQ, INCR4,  1'b1, 4'b0010, 2'd1, 2'd0, 1'b1, M_GSH);
    applyStimulus("i4_b2",    1'b1, 4'b1010, SEQ,    INCR4,  1'b1, 4'b0010, 2'd1, 2'd1, 1'b1, M_ALL);
    applyStimulus("i4_wait1", 1'b1, 4'b1010, SEQ,    INCR4,  1'b0, 4'b0010, 2'd1, 2'd1, 1'b1, M_ALL);
    applyStimulus("i4_wait2", 1'b1, 4'b1010, SEQ,    INCR4,  1'b0, 4'b0010, 2'd1, 2'd1, 1'b1, M_ALL);
    applyStimulus("i4_b3",    1'b1, 4'b1010, SEQ,    INCR4,  1'b1, 4'b0010, 2'd1, 2'd1, 1'b1, M_ALL);
    applyStimulus("i4_b4",    1'b1, 4'b1010, SEQ,    INCR4,  1'b1, 4'b0010, 2'd1, 2'd1, 1'b1, M_ALL);
    applyStimulus("i4_m3",    1'b1, 4'b1000, NONSEQ, SINGLE, 1'b1, 4'b1000, 2'd3, 2'd1, 1'b1, M_ALL);
    applyStimulus("i4_end",   1'b1, 4'b0000, IDLE,   SINGLE, 1'b1, 4'b1000, 2'd3, 2'd3, 1'b0, M_ALL);
    applyStimulus("i4_idle",  1'b1, 4'b0000, IDLE,   SINGLE, 1'b1, 4'b0000, 2'd0, 2'd0, 1'b0, M_GH);

    // Undefined-length INCR from master 0 with a BUSY; master 2 waits for IDLE.
    applyStimulus("inc_req",  1'b1, 4'b0001, IDLE,   INCR,   1'b1, 4'b0000, 2'd0, 2'd0, 1'b0, M_GH);
    applyStimulus("inc_ns",   1'b1, 4'b0101, NONSEQ, INCR,   1'b1, 4'b0001, 2'd0, 2'd0, 1'b1, M_GSH);
    applyStimulus("inc_s1",   1'b1, 4'b0101, SEQ,    INCR,   1'b1, 4'b0001, 2'd0, 2'd0, 1'b1, M_ALL);
    applyStimulus("inc_s2",   1'b1, 4'b0101, SEQ,    INCR,   1'b1, 4'b0001, 2'd0, 2'd0, 1'b1, M_ALL);
    applyStimulus("inc_busy", 1'b1, 4'b0101, BUSY,   INCR,   1'b1, 4'b0001, 2'd0, 2'd0, 1'b0, M_ALL);
    for (int k = 0; k < 7; k++) begin
      applyStimulus("inc_sn", 1'b1, 4'b0101, SEQ,    INCR,   1'b1, 4'b0001, 2'd0, 2'd0, 1'b1, M_ALL);
    end
    applyStimulus("inc_idw",  1'b1, 4'b0101, IDLE,   INCR,   1'b0, 4'b0001, 2'd0, 2'd0, 1'b0, M_ALL);
    applyStimulus("inc_idr",  1'b1, 4'b0101, IDLE,   INCR,   1'b1, 4'b0001, 2'd0, 2'd0, 1'b0, M_ALL);
    applyStimulus("inc_m2",   1'b1, 4'b0100, NONSEQ, SINGLE, 1'b1, 4'b0100, 2'd2, 2'd0, 1'b1, M_ALL);
    applyStimulus("inc_end",  1'b1, 4'b0000, IDLE,   SINGLE, 1'b1, 4'b0100, 2'd2, 2'd2, 1'b0, M_ALL);
    applyStimulus("inc_idle", 1'b1, 4'b0000, IDLE,   SINGLE, 1'b1, 4'b0000, 2'd0, 2'd0, 1'b0, M_GH);

`ifdef AHB_ARB_LOCK_EN
    // Locked master 2 over two INCR4 bursts; master 0 waits for the unlocked last beat.
    lock_next = 1'b0;
    applyStimulus("lk_req",   1'b1, 4'b0100, IDLE,   INCR4,  1'b1, 4'b0000, 2'd0, 2'd0, 1'b0, M_GH);
    lock_next = 1'b1;
    applyStimulus("lk_a1",    1'b1, 4'b0101, NONSEQ, INCR4,  1'b1, 4'b0100, 2'd2, 2'd0, 1'b1, M_GSH);
    applyStimulus("lk_a2",    1'b1, 4'b0101, SEQ,    INCR4,  1'b1, 4'b0100, 2'd2, 2'd2, 1'b1, M_ALL);
    applyStimulus("lk_a3",    1'b1, 4'b0101, SEQ,    INCR4,  1'b1, 4'b0100, 2'd2, 2'd2, 1'b1, M_ALL);
    applyStimulus("lk_a4",    1'b1, 4'b0101, SEQ,    INCR4,  1'b1, 4'b0100, 2'd2, 2'd2, 1'b1, M_ALL);
    applyStimulus("lk_idle",  1'b1, 4'b0101, IDLE,   INCR4,  1'b1, 4'b0100, 2'd2, 2'd2, 1'b0, M_ALL);
    applyStimulus("lk_b1",    1'b1, 4'b0101, NONSEQ, INCR4,  1'b1, 4'b0100, 2'd2, 2'd2, 1'b1, M_ALL);
    applyStimulus("lk_b2",    1'b1, 4'b0101, SEQ,    INCR4,  1'b1, 4'b0100, 2'd2, 2'd2, 1'b1, M_ALL);
    applyStimulus("lk_b3",    1'b1, 4'b0101, SEQ,    INCR4,  1'b1, 4'b0100, 2'd2, 2'd2, 1'b1, M_ALL);
    lock_next = 1'b0;
    applyStimulus("lk_b4",    1'b1, 4'b0101, SEQ,    INCR4,  1'b1, 4'b0100, 2'd2, 2'd2, 1'b1, M_ALL);
    applyStimulus("lk_m0",    1'b1, 4'b0001, NONSEQ, SINGLE, 1'b1, 4'b0001, 2'd0, 2'd2, 1'b1, M_ALL);
    applyStimulus("lk_end",   1'b1, 4'b0000, IDLE,   SINGLE, 1'b1, 4'b0001, 2'd0, 2'd0, 1'b0, M_ALL);
    applyStimulus("lk_gone",  1'b1, 4'b0000, IDLE,   SINGLE, 1'b1, 4'b0000, 2'd0, 2'd0, 1'b0, M_GH);
`endif

    // Reset in the middle of an INCR8 during a wait state, then re-grant.
    applyStimulus("rs_req",   1'b1, 4'b0100, IDLE,   INCR8,  1'b1, 4'b0000, 2'd0, 2'd0, 1'b0, M_GH);
    applyStimulus("rs_b1",    1'b1, 4'b0100, NONSEQ, INCR8,  1'b1, 4'b0100, 2'd2, 2'd0, 1'b1, M_GSH);
    applyStimulus("rs_b2",    1'b1, 4'b0100, SEQ,    INCR8,  1'b1, 4'b0100, 2'd2, 2'd2, 1'b1, M_ALL);
    applyStimulus("rs_wait",  1'b1, 4'b0100, SEQ,    INCR8,  1'b0, 4'b0100, 2'd2, 2'd2, 1'b1, M_ALL);
    applyStimulus("rs_assert",1'b0, 4'b0100, SEQ,    INCR8,  1'b0, 4'b0000, 2'd0, 2'd0, 1'b0, M_ALL);
    applyStimulus("rs_rel",   1'b1, 4'b0100, IDLE,   SINGLE, 1'b1, 4'b0000, 2'd0, 2'd0, 1'b0, M_ALL);
    applyStimulus("rs_grant", 1'b1, 4'b0100, NONSEQ, SINGLE, 1'b1, 4'b0100, 2'd2, 2'd0, 1'b1, M_ALL);
    applyStimulus("rs_end",   1'b1, 4'b0000, IDLE,   SINGLE, 1'b1, 4'b0100, 2'd2, 2'd2, 1'b0, M_ALL);
    applyStimulus("rs_idle",  1'b1, 4'b0000, IDLE,   SINGLE, 1'b1, 4'b0000, 2'd0, 2'd0, 1'b0, M_GH);

    stim_done = 1'b1;
  end

endmodule
